// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and exception codes for the P8 core
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] EXC_ADEL   = 5'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/cti_detect.sv
// rtl/cti_detect.sv - flags control-transfer instructions (branches, jumps) that own a delay slot
module cti_detect
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_cti
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_mid_bits;

  assign opcode          = ir[31:26];
  assign funct           = ir[5:0];
  assign unused_mid_bits = ^ir[25:6];

  always_comb begin
    is_cti = 1'b0;
    case (opcode)
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_cti = 1'b1;
      OP_SPECIAL: is_cti = (funct == FN_JR) || (funct == FN_JALR);
      default:    is_cti = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// rtl/if_id_stage_reg.sv - IF/ID pipeline register with bubble, freeze and delay-slot tracking; IFID_PERF_EN adds stall/bubble counters
module if_id_stage_reg #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [4:0]  EXC_ADEL  = mips_pkg::EXC_ADEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_ir,
  input  logic [31:0] if_pcp4,
  input  logic        if_pc_exc,
  input  logic        goto_handler,
  input  logic        eret,
  input  logic        freeze,
  output logic [31:0] id_ir,
  output logic [31:0] id_pcp4,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_exc,
  output logic [4:0]  id_exc_code,
  output logic        id_bd,
  output logic [31:0] id_epc,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  logic id_is_cti;
  logic bubble;

  cti_detect u_cti_detect (
    .ir     (id_ir),
    .is_cti (id_is_cti)
  );

  // ERET only kills the slot when the pipe is moving; handler entry always does
  assign bubble = goto_handler | (eret & ~freeze);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ir       <= mips_pkg::NOP_INSTR;
      id_pcp4     <= TEXT_BASE + 32'd4;
      id_valid    <= 1'b0;
      id_exc      <= 1'b0;
      id_exc_code <= 5'd0;
      id_bd       <= 1'b0;
    end else if (bubble) begin
      id_ir       <= mips_pkg::NOP_INSTR;
      id_pcp4     <= if_pcp4;
      id_valid    <= 1'b0;
      id_exc      <= 1'b0;
      id_exc_code <= 5'd0;
      id_bd       <= 1'b0;
    end else if (!freeze) begin
      id_ir       <= if_ir;
      id_pcp4     <= if_pcp4;
      id_valid    <= 1'b1;
      id_exc      <= if_pc_exc;
      id_exc_code <= if_pc_exc ? EXC_ADEL : 5'd0;
      // the incoming instruction is a delay slot iff the one leaving ID was a real CTI
      id_bd       <= id_valid & id_is_cti;
    end
  end

  assign id_pc  = id_pcp4 - 32'd4;
  assign id_epc = id_bd ? (id_pc - 32'd4) : id_pc;

`ifdef IFID_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= 32'd0;
      bubble_q <= 32'd0;
    end else begin
      if (freeze && !goto_handler && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (bubble && (bubble_q != 32'hFFFF_FFFF))
        bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb/tb_if_id_stage_reg.sv - self-checking bench: directed vector table, hand sequence, randomized model compare
module tb_if_id_stage_reg;

`ifdef IFID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_ir, if_pcp4;
  logic        if_pc_exc, goto_handler, eret, freeze;
  logic [31:0] id_ir, id_pcp4, id_pc, id_epc, stall_cnt, bubble_cnt;
  logic        id_valid, id_exc, id_bd;
  logic [4:0]  id_exc_code;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  if_id_stage_reg dut (
    .clk(clk), .reset(reset), .if_ir(if_ir), .if_pcp4(if_pcp4), .if_pc_exc(if_pc_exc),
    .goto_handler(goto_handler), .eret(eret), .freeze(freeze),
    .id_ir(id_ir), .id_pcp4(id_pcp4), .id_pc(id_pc), .id_valid(id_valid), .id_exc(id_exc),
    .id_exc_code(id_exc_code), .id_bd(id_bd), .id_epc(id_epc),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic [31:0] ir, input logic [31:0] pcp4,
                       input logic exc, input logic gh, input logic er, input logic frz);
    @(negedge clk);
    reset = rst; if_ir = ir; if_pcp4 = pcp4; if_pc_exc = exc;
    goto_handler = gh; eret = er; freeze = frz;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  typedef struct {
    logic        rst;
    logic [31:0] ir, pcp4;
    logic        exc, gh, er, frz;
    logic [31:0] e_ir, e_pc;
    logic        e_valid, e_exc, e_bd;
    logic [31:0] e_epc, e_stall, e_bubble;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [31:0] m_ir, m_pcp4, m_stall, m_bubble;
  logic        m_valid, m_exc, m_bd;

  function automatic bit ref_cti(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'd0) return (w[5:0] == 6'd8) || (w[5:0] == 6'd9);
    return (op >= 6'd1) && (op <= 6'd7);
  endfunction

  task automatic model_step(input logic rst, input logic [31:0] ir, input logic [31:0] pcp4,
                            input logic exc, input logic gh, input logic er, input logic frz);
    if (rst) begin
      m_ir = 0; m_pcp4 = 32'h3004; m_valid = 0; m_exc = 0; m_bd = 0;
      m_stall = 0; m_bubble = 0;
    end else begin
      if (PERF && frz && !gh && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (gh || (er && !frz)) begin
        if (PERF && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        m_ir = 0; m_pcp4 = pcp4; m_valid = 0; m_exc = 0; m_bd = 0;
      end else if (!frz) begin
        m_bd    = m_valid && ref_cti(m_ir);
        m_ir    = ir; m_pcp4 = pcp4; m_valid = 1; m_exc = exc;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".ir"},     id_ir,      m_ir);
    check({tag, ".pc"},     id_pc,      m_pcp4 - 32'd4);
    check({tag, ".valid"},  id_valid,   m_valid);
    check({tag, ".exc"},    id_exc,     m_exc);
    check({tag, ".code"},   id_exc_code, m_exc ? 32'd4 : 32'd0);
    check({tag, ".bd"},     id_bd,      m_bd);
    check({tag, ".epc"},    id_epc,     m_bd ? m_pcp4 - 32'd8 : m_pcp4 - 32'd4);
    check({tag, ".stall"},  stall_cnt,  m_stall);
    check({tag, ".bubble"}, bubble_cnt, m_bubble);
  endtask

  initial begin
    reset = 1; if_ir = 0; if_pcp4 = 0; if_pc_exc = 0; goto_handler = 0; eret = 0; freeze = 0;

    //         rst ir            pcp4          exc gh er frz  e_ir          e_pc          v  x  bd  e_epc         stall    bubble
    tbl.push_back('{1, 32'hDEAD_BEEF, 32'h9999_9990, 0, 0, 0, 0, 32'h0,         32'h3000,     0, 0, 0, 32'h3000,     pc_(0), pc_(0)});
    tbl.push_back('{0, 32'h2401_0005, 32'h0000_3004, 0, 0, 0, 0, 32'h2401_0005, 32'h3000,     1, 0, 0, 32'h3000,     pc_(0), pc_(0)});
    tbl.push_back('{0, 32'h1000_0003, 32'h0000_3004, 0, 0, 0, 0, 32'h1000_0003, 32'h3000,     1, 0, 0, 32'h3000,     pc_(0), pc_(0)});
    tbl.push_back('{0, 32'h0022_1821, 32'h0000_3008, 0, 0, 0, 0, 32'h0022_1821, 32'h3004,     1, 0, 1, 32'h3000,     pc_(0), pc_(0)});
    tbl.push_back('{0, 32'h2402_0001, 32'h0000_300C, 0, 0, 0, 0, 32'h2402_0001, 32'h3008,     1, 0, 0, 32'h3008,     pc_(0), pc_(0)});
    tbl.push_back('{0, 32'h1111_1111, 32'h0000_5000, 0, 0, 0, 1, 32'h2402_0001, 32'h3008,     1, 0, 0, 32'h3008,     pc_(1), pc_(0)});
    tbl.push_back('{0, 32'h0800_0000, 32'h0000_5004, 1, 0, 0, 1, 32'h2402_0001, 32'h3008,     1, 0, 0, 32'h3008,     pc_(2), pc_(0)});
    tbl.push_back('{0, 32'h03E0_0008, 32'h0000_5008, 0, 0, 0, 1, 32'h2402_0001, 32'h3008,     1, 0, 0, 32'h3008,     pc_(3), pc_(0)});
    tbl.push_back('{0, 32'h2403_0002, 32'h0000_3010, 0, 1, 0, 1, 32'h0,         32'h300C,     0, 0, 0, 32'h300C,     pc_(3), pc_(1)});
    tbl.push_back('{0, 32'h03E0_0008, 32'h0000_4004, 0, 0, 0, 0, 32'h03E0_0008, 32'h4000,     1, 0, 0, 32'h4000,     pc_(3), pc_(1)});
    tbl.push_back('{0, 32'h0,         32'h0000_3003, 1, 0, 0, 0, 32'h0,         32'h2FFF,     1, 1, 1, 32'h2FFB,     pc_(3), pc_(1)});
    tbl.push_back('{0, 32'h2404_0003, 32'h0000_3010, 0, 0, 0, 0, 32'h2404_0003, 32'h300C,     1, 0, 0, 32'h300C,     pc_(3), pc_(1)});
    tbl.push_back('{0, 32'h2405_0004, 32'h0000_6000, 0, 0, 1, 1, 32'h2404_0003, 32'h300C,     1, 0, 0, 32'h300C,     pc_(4), pc_(1)});
    tbl.push_back('{0, 32'h2405_0004, 32'h0000_3014, 0, 0, 1, 0, 32'h0,         32'h3010,     0, 0, 0, 32'h3010,     pc_(4), pc_(2)});
    tbl.push_back('{0, 32'h0800_0C00, 32'h0000_3018, 0, 0, 0, 0, 32'h0800_0C00, 32'h3014,     1, 0, 0, 32'h3014,     pc_(4), pc_(2)});
    tbl.push_back('{0, 32'h2406_0005, 32'h0000_301C, 0, 1, 0, 0, 32'h0,         32'h3018,     0, 0, 0, 32'h3018,     pc_(4), pc_(3)});
    tbl.push_back('{0, 32'h0022_1821, 32'h0000_3020, 0, 0, 0, 0, 32'h0022_1821, 32'h301C,     1, 0, 0, 32'h301C,     pc_(4), pc_(3)});

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ir, tbl[i].pcp4, tbl[i].exc, tbl[i].gh, tbl[i].er, tbl[i].frz);
      check($sformatf("v%0d.ir", i),     id_ir,       tbl[i].e_ir);
      check($sformatf("v%0d.pc", i),     id_pc,       tbl[i].e_pc);
      check($sformatf("v%0d.valid", i),  id_valid,    tbl[i].e_valid);
      check($sformatf("v%0d.exc", i),    id_exc,      tbl[i].e_exc);
      check($sformatf("v%0d.code", i),   id_exc_code, tbl[i].e_exc ? 32'd4 : 32'd0);
      check($sformatf("v%0d.bd", i),     id_bd,       tbl[i].e_bd);
      check($sformatf("v%0d.epc", i),    id_epc,      tbl[i].e_epc);
      check($sformatf("v%0d.stall", i),  stall_cnt,   tbl[i].e_stall);
      check($sformatf("v%0d.bubble", i), bubble_cnt,  tbl[i].e_bubble);
    end

    // jal held through a freeze still marks the following capture as a delay slot
    drive(0, 32'h0C00_0100, 32'h0000_7004, 0, 0, 0, 0);
    drive(0, 32'h0000_0000, 32'h0000_7008, 0, 0, 0, 1);
    drive(0, 32'h0000_0000, 32'h0000_7008, 0, 0, 0, 1);
    check("hs.frozen_bd", id_bd, 32'd0);
    check("hs.frozen_ir", id_ir, 32'h0C00_0100);
    drive(0, 32'h0000_0000, 32'h0000_7008, 0, 0, 0, 0);
    check("hs.slot_bd",  id_bd,  32'd1);
    check("hs.slot_epc", id_epc, 32'h0000_7000);

    // randomized comparison against the reference model
    drive(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    compare_model("rst");
    for (int n = 0; n < 3000; n++) begin
      logic        r, x, g, e, f;
      logic [31:0] w, p;
      logic [5:0]  fn;
      r = ($urandom_range(0, 99) == 0);
      g = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 3) == 0);
      x = ($urandom_range(0, 7) == 0);
      p = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | (x ? 32'(1 + $urandom_range(0, 2)) : 32'd0);
      case ($urandom_range(0, 2))
        0: w = {6'(1 + $urandom_range(0, 6)), 26'($urandom)};
        1: begin
          case ($urandom_range(0, 2))
            0: fn = 6'd8;
            1: fn = 6'd9;
            default: fn = 6'h21;
          endcase
          w = {6'd0, 20'($urandom), fn};
        end
        default: w = $urandom;
      endcase
      if (x) w = 0;
      drive(r, w, p, x, g, e, f);
      model_step(r, w, p, x, g, e, f);
      compare_model($sformatf("r%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
